// File: rtl/ext_razor_monitor.sv
// Purpose: registers (optionally 0.75-scaled, `ifdef EXT_SCALE_EN) extrinsic as next a-priori value; counts Razor errors per frame and requests DVFS up/down.
// Latency: ba1_next/ba1_valid 1 cycle after the accepted sample; vdd_up/vdd_down pulse in the single EVAL cycle after the final strobe.
// Backpressure: none; samples outside RUN are dropped, start outside IDLE is ignored.
module ext_razor_monitor #(
  parameter int M             = 6,
  parameter int CNT_W         = 8,
  parameter int NUM_HALF_ITER = 16,
  parameter int THRESH        = 4
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic                start,
  input  logic                iter_valid,
  input  logic signed [M-1:0] be1_TrueQ,
  input  logic                Error_current_be1,
  output logic signed [M-1:0] ba1_next,
  output logic                ba1_valid,
  output logic [CNT_W-1:0]    err_count,
  output logic                vdd_up,
  output logic                vdd_down,
  output logic                busy
);

  localparam int SW = $clog2(NUM_HALF_ITER + 1);
  localparam logic [SW-1:0]    LAST     = SW'(NUM_HALF_ITER - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  typedef enum logic [1:0] {IDLE, RUN, EVAL} state_t;

  state_t             state, state_nxt;
  logic [SW-1:0]      strobe_cnt, strobe_nxt;
  logic [CNT_W-1:0]   err_nxt;
  logic               sample;
  logic               last_strobe;
  logic signed [M-1:0] scaled;

  assign sample      = (state == RUN) && iter_valid;
  assign last_strobe = sample && (strobe_cnt == LAST);

`ifdef EXT_SCALE_EN
  // x - x/4 never exceeds the input magnitude, so M bits hold the exact result
  assign scaled = be1_TrueQ - (be1_TrueQ >>> 2);
`else
  assign scaled = be1_TrueQ;
`endif

  always_comb begin
    state_nxt  = state;
    strobe_nxt = strobe_cnt;
    err_nxt    = err_count;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = RUN;
          strobe_nxt = '0;
          err_nxt    = '0;
        end
      end
      RUN: begin
        if (sample) begin
          strobe_nxt = strobe_cnt + SW'(1);
          if (Error_current_be1 && (err_count != CNT_MAX))
            err_nxt = err_count + CNT_W'(1);
          if (last_strobe)
            state_nxt = EVAL;
        end
      end
      EVAL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      strobe_cnt <= '0;
      err_count  <= '0;
      ba1_next   <= '0;
      ba1_valid  <= 1'b0;
      vdd_up     <= 1'b0;
      vdd_down   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      strobe_cnt <= strobe_nxt;
      err_count  <= err_nxt;
      ba1_valid  <= sample;
      if (sample)
        ba1_next <= scaled;
      // decision uses err_nxt so an error on the final strobe is counted
      vdd_up     <= last_strobe && (err_nxt >= THRESH_C);
      vdd_down   <= last_strobe && (err_nxt == '0);
      busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_ext_razor_monitor.sv
// Bench for ext_razor_monitor: default instance plus a CNT_W=2/THRESH=3 instance sharing stimulus.
module tb_ext_razor_monitor;

  localparam int M = 6;

  typedef struct {
    int err;
    int up;
    int dn;
  } fexp_t;

  logic Clock = 1'b0;
  logic nReset;
  logic start;
  logic iter_valid;
  logic [M-1:0] be1;
  logic err_in;

  logic [M-1:0] ba1_next, ba1_next2;
  logic ba1_valid, ba1_valid2;
  logic [7:0] err_count;
  logic [1:0] err_count2;
  logic vdd_up, vdd_up2, vdd_down, vdd_down2, busy, busy2;

  int n_checks = 0;
  int n_fail   = 0;

  int    q1[$], q2[$];
  fexp_t fq1[$], fq2[$];

  // stimulus values and their hand-computed 0.75-scaled results
  int tin[16]  = '{-32, 31, -1, 4, 5, 7, -5, 12, -8, 0, 16, -17, 10, -2, -31, 20};
  int tout[16] = '{-24, 24,  0, 3, 4, 6, -3,  9, -6, 0, 12, -12,  8, -1, -23, 15};

  ext_razor_monitor dut (
    .Clock(Clock), .nReset(nReset), .start(start), .iter_valid(iter_valid),
    .be1_TrueQ(be1), .Error_current_be1(err_in),
    .ba1_next(ba1_next), .ba1_valid(ba1_valid), .err_count(err_count),
    .vdd_up(vdd_up), .vdd_down(vdd_down), .busy(busy)
  );

  ext_razor_monitor #(.CNT_W(2), .THRESH(3)) dut_sat (
    .Clock(Clock), .nReset(nReset), .start(start), .iter_valid(iter_valid),
    .be1_TrueQ(be1), .Error_current_be1(err_in),
    .ba1_next(ba1_next2), .ba1_valid(ba1_valid2), .err_count(err_count2),
    .vdd_up(vdd_up2), .vdd_down(vdd_down2), .busy(busy2)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int expected_ba1(input int idx);
`ifdef EXT_SCALE_EN
    return tout[idx];
`else
    return tin[idx];
`endif
  endfunction

  task automatic strobe(input int idx, input bit e);
    iter_valid = 1'b1;
    be1        = M'(tin[idx]);
    err_in     = e;
    q1.push_back(expected_ba1(idx));
    q2.push_back(expected_ba1(idx));
    @(posedge Clock); #1;
    iter_valid = 1'b0;
    err_in     = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
  endtask

  task automatic push_frame(input int e);
    fexp_t f;
    int sat;
    f.err = e; f.up = (e >= 4) ? 1 : 0; f.dn = (e == 0) ? 1 : 0;
    fq1.push_back(f);
    sat = (e > 3) ? 3 : e;
    f.err = sat; f.up = (sat >= 3) ? 1 : 0; f.dn = (e == 0) ? 1 : 0;
    fq2.push_back(f);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic frame(input bit [16:1] emask);
    int e;
    e = 0;
    pulse_start();
    check("busy_rise", int'(busy), 1);
    for (int i = 1; i <= 16; i++) begin
      if (emask[i]) e++;
      strobe(i - 1, emask[i]);
    end
    push_frame(e);
    idle(4);
  endtask

  // monitor for the default instance
  int  up_c1, dn_c1, last_up1, last_dn1;
  bit  pb1;
  always @(negedge Clock) begin
    if (!nReset) begin
      up_c1 = 0; dn_c1 = 0; last_up1 = 0; last_dn1 = 0; pb1 = 0;
    end else begin
      if (ba1_valid) begin
        if (q1.size() == 0) check("ba1_unexpected", 1, 0);
        else check("ba1_next", int'($signed(ba1_next)), q1.pop_front());
      end
      if (busy) begin
        up_c1 += int'(vdd_up); dn_c1 += int'(vdd_down);
        last_up1 = int'(vdd_up); last_dn1 = int'(vdd_down);
      end else begin
        check("vdd_idle", int'(vdd_up | vdd_down), 0);
      end
      if (pb1 && !busy) begin
        if (fq1.size() == 0) check("frame_unexpected", 1, 0);
        else begin
          fexp_t f;
          f = fq1.pop_front();
          check("err_count", int'(err_count), f.err);
          check("vdd_up_pulses", up_c1, f.up);
          check("vdd_down_pulses", dn_c1, f.dn);
          check("vdd_up_in_eval", last_up1, f.up);
          check("vdd_down_in_eval", last_dn1, f.dn);
        end
        up_c1 = 0; dn_c1 = 0;
      end
      pb1 = busy;
    end
  end

  // monitor for the saturating instance
  int  up_c2, dn_c2, last_up2, last_dn2;
  bit  pb2;
  always @(negedge Clock) begin
    if (!nReset) begin
      up_c2 = 0; dn_c2 = 0; last_up2 = 0; last_dn2 = 0; pb2 = 0;
    end else begin
      if (ba1_valid2) begin
        if (q2.size() == 0) check("sat_ba1_unexpected", 1, 0);
        else check("sat_ba1_next", int'($signed(ba1_next2)), q2.pop_front());
      end
      if (busy2) begin
        up_c2 += int'(vdd_up2); dn_c2 += int'(vdd_down2);
        last_up2 = int'(vdd_up2); last_dn2 = int'(vdd_down2);
      end
      if (pb2 && !busy2) begin
        if (fq2.size() == 0) check("sat_frame_unexpected", 1, 0);
        else begin
          fexp_t f;
          f = fq2.pop_front();
          check("sat_err_count", int'(err_count2), f.err);
          check("sat_vdd_up_pulses", up_c2, f.up);
          check("sat_vdd_down_pulses", dn_c2, f.dn);
          check("sat_vdd_up_in_eval", last_up2, f.up);
          check("sat_vdd_down_in_eval", last_dn2, f.dn);
        end
        up_c2 = 0; dn_c2 = 0;
      end
      pb2 = busy2;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    nReset = 1'b0; start = 1'b0; iter_valid = 1'b0; be1 = '0; err_in = 1'b0;
    #3;
    check("rst_ba1_next", int'(ba1_next), 0);
    check("rst_ba1_valid", int'(ba1_valid), 0);
    check("rst_err_count", int'(err_count), 0);
    check("rst_vdd_up", int'(vdd_up), 0);
    check("rst_vdd_down", int'(vdd_down), 0);
    check("rst_busy", int'(busy), 0);
    idle(2);
    nReset = 1'b1;
    idle(2);

    // errors on strobes 3, 7, 15, 16
    frame(16'b1100_0000_0100_0100);

    // three errors: below threshold, count held afterwards
    frame(16'h0007);
    idle(3);
    check("hold_err_count", int'(err_count), 3);
    check("hold_sat_err_count", int'(err_count2), 3);
    check("hold_busy", int'(busy), 0);

    // asynchronous reset mid-RUN after 5 strobes with 2 errors
    pulse_start();
    for (int i = 0; i < 5; i++) strobe(i, (i == 1) || (i == 3));
    idle(1);
    #1 nReset = 1'b0;
    #1;
    check("arst_ba1_next", int'(ba1_next), 0);
    check("arst_ba1_valid", int'(ba1_valid), 0);
    check("arst_err_count", int'(err_count), 0);
    check("arst_vdd_up", int'(vdd_up), 0);
    check("arst_vdd_down", int'(vdd_down), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_sat_busy", int'(busy2), 0);
    @(posedge Clock); #1;
    nReset = 1'b1;
    idle(1);
    frame(16'h0000);

    // start with iter_valid in IDLE, then a start mid-RUN
    start = 1'b1; iter_valid = 1'b1; be1 = M'(7); err_in = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0; iter_valid = 1'b0; err_in = 1'b0;
    for (int i = 1; i <= 8; i++) strobe(i - 1, i <= 2);
    pulse_start();
    for (int i = 9; i <= 16; i++) strobe(i - 1, 1'b0);
    push_frame(2);
    idle(4);

    // six errors: saturates the 2-bit counter
    frame(16'h0555);

    idle(3);
    check("ba1_queue_drained", q1.size() + q2.size(), 0);
    check("frame_queue_drained", fq1.size() + fq2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
